// File: rtl/ct_lsu_sram7_access_ctrl.sv
// Initiator-side controller for a 256x7 single-port SRAM with active-low
// CEN/GWEN/WEN. Turns a valid/ready read / masked-write request stream into
// SRAM pin sequencing and returns read data through a one-entry response
// buffer. After reset, or on a clear request, every entry is walked to INIT_VAL.
module ct_lsu_sram7_access_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 7,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic                  clr_req,
  output logic                  init_done,
  input  logic                  req_vld,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  req_ready,
  output logic                  rsp_vld,
  output logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  rsp_ready,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_next_cnt;
  logic                  r_rd_s1;
  logic                  r_clr_pend;
  logic                  r_rsp_vld;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [ADDR_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_d;
  logic [ADDR_WIDTH-1:0] w_a;
  logic [DATA_WIDTH-1:0] w_d;
  logic                  w_clr_seen;
  logic                  w_rd_acc;

  // A clear is live when requested now or parked behind an in-flight read.
  assign w_clr_seen = (r_state == ST_IDLE) && (clr_req || r_clr_pend);

  // Next-state and pin decode; reset forces every pin and handshake idle.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_rd_acc     = 1'b0;
    w_a          = r_a;
    w_d          = r_d;
    init_done    = 1'b0;
    req_ready    = 1'b0;
    sram_cen     = 1'b1;
    sram_gwen    = 1'b1;
    sram_wen     = '1;
    if (!cpurst) begin
      case (r_state)
        ST_INIT: begin
          sram_cen   = 1'b0;
          sram_gwen  = 1'b0;
          sram_wen   = '0;
          w_a        = r_cnt;
          w_d        = INIT_VAL;
          w_next_cnt = r_cnt + ADDR_WIDTH'(1);
          if (r_cnt == '1) begin
            w_next_state = ST_IDLE;
          end
        end
        default: begin
          init_done = 1'b1;
          if (w_clr_seen) begin
            if (!r_rd_s1) begin
              w_next_state = ST_INIT;
              w_next_cnt   = '0;
            end
          end else begin
            if (req_wr) begin
              req_ready = 1'b1;
            end else begin
              req_ready = !r_rd_s1 && (!r_rsp_vld || rsp_ready);
            end
            if (req_vld && req_ready) begin
              w_a = req_addr;
              if (req_wr) begin
                w_d = req_wdata;
                if (req_wmask != '0) begin
                  sram_cen  = 1'b0;
                  sram_gwen = 1'b0;
                  sram_wen  = ~req_wmask;
                end
              end else begin
                sram_cen = 1'b0;
                w_rd_acc = 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  assign sram_a   = w_a;
  assign sram_d   = w_d;
  assign rsp_vld  = r_rsp_vld && !cpurst;
  assign rsp_data = cpurst ? '0 : r_rsp_data;

  // State register, walk counter, read pipeline flag and parked clear.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_state    <= ST_INIT;
      r_cnt      <= '0;
      r_rd_s1    <= 1'b0;
      r_clr_pend <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_rd_s1    <= w_rd_acc;
      r_clr_pend <= w_clr_seen && r_rd_s1;
    end
  end

  // Address/data hold registers so idle cycles keep the last driven values.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_a <= '0;
      r_d <= '0;
    end else begin
      r_a <= w_a;
      r_d <= w_d;
    end
  end

  // Response buffer: capture Q one cycle after the read edge, drop on drain.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_rsp_vld  <= 1'b0;
      r_rsp_data <= '0;
    end else if (r_rd_s1) begin
      r_rsp_vld  <= 1'b1;
      r_rsp_data <= sram_q;
    end else if (r_rsp_vld && rsp_ready) begin
      r_rsp_vld  <= 1'b0;
    end
  end

endmodule
